range_down_counter: RTL and testbench

Programmable synchronous down-counter, the counting-direction complement of the team's up-counting range counter (3→12 wrap). It counts from an upper bound `hi` down to a lower bound `lo`, then either wraps back to `hi` or stops, depending on mode. It sits next to the up-counter in the timing and sequence-generation logic and supplies descending sequences, terminal-count strobes and a wrap tally. All outputs are registered.

---
 rtl/range_down_counter.sv | 133 +++++++++++++
 tb/tb_range_down_counter.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/range_down_counter.sv
// Programmable down-counter: counts from a latched upper bound to a latched lower bound,
// then wraps (continuous) or parks in DONE (one-shot). All outputs are registered.
module range_down_counter #(
  parameter int unsigned WIDTH  = 4,
  parameter int unsigned HI_DEF = 12,
  parameter int unsigned LO_DEF = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_start,
  input  logic             i_stop,
  input  logic             i_oneshot,
  input  logic             i_en,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_val,
  input  logic [WIDTH-1:0] i_hi,
  input  logic [WIDTH-1:0] i_lo,
  output logic [WIDTH-1:0] o_count,
  output logic             o_busy,
  output logic             o_tc,
  output logic             o_done,
  output logic [7:0]       o_wraps,
  output logic             o_cfg_err
);

  localparam logic [WIDTH-1:0] HiDef = WIDTH'(HI_DEF);
  localparam logic [WIDTH-1:0] LoDef = WIDTH'(LO_DEF);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           r_state, w_state_d;
  logic [WIDTH-1:0] r_count, w_count_d;
  logic [WIDTH-1:0] r_hi, w_hi_d;
  logic [WIDTH-1:0] r_lo, w_lo_d;
  logic             r_oneshot, w_oneshot_d;
  logic [7:0]       r_wraps, w_wraps_d;
  logic             r_busy, w_busy_d;
  logic             r_tc, w_tc_d;
  logic             r_done, w_done_d;
  logic             r_cfg_err, w_cfg_err_d;

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= StIdle;
      r_count   <= HiDef;
      r_hi      <= HiDef;
      r_lo      <= LoDef;
      r_oneshot <= 1'b0;
      r_wraps   <= 8'd0;
      r_busy    <= 1'b0;
      r_tc      <= 1'b0;
      r_done    <= 1'b0;
      r_cfg_err <= 1'b0;
    end else begin
      r_state   <= w_state_d;
      r_count   <= w_count_d;
      r_hi      <= w_hi_d;
      r_lo      <= w_lo_d;
      r_oneshot <= w_oneshot_d;
      r_wraps   <= w_wraps_d;
      r_busy    <= w_busy_d;
      r_tc      <= w_tc_d;
      r_done    <= w_done_d;
      r_cfg_err <= w_cfg_err_d;
    end
  end

  // Next-state and datapath; stop outranks everything below reset
  always_comb begin
    w_state_d   = r_state;
    w_count_d   = r_count;
    w_hi_d      = r_hi;
    w_lo_d      = r_lo;
    w_oneshot_d = r_oneshot;
    w_wraps_d   = r_wraps;
    w_cfg_err_d = 1'b0;
    if (i_stop) begin
      w_state_d = StIdle;
    end else begin
      unique case (r_state)
        StIdle, StDone: begin
          if (i_start) begin
            if (i_hi < i_lo) begin
              w_cfg_err_d = 1'b1;
            end else begin
              w_state_d   = StRun;
              w_hi_d      = i_hi;
              w_lo_d      = i_lo;
              w_oneshot_d = i_oneshot;
              w_count_d   = i_hi;
              w_wraps_d   = 8'd0;
            end
          end
        end
        StRun: begin
          if (i_load) begin
            if ((i_load_val >= r_lo) && (i_load_val <= r_hi)) begin
              w_count_d = i_load_val;
            end else begin
              w_cfg_err_d = 1'b1;
            end
          end else if (i_en) begin
            if (r_count != r_lo) begin
              w_count_d = r_count - 1'b1;
            end else if (r_oneshot) begin
              w_state_d = StDone;
            end else begin
              w_count_d = r_hi;
              if (r_wraps != 8'hFF) w_wraps_d = r_wraps + 8'd1;
            end
          end
        end
        default: w_state_d = StIdle;
      endcase
    end
  end

  // Status flags from next-state values so they line up with the registered count
  always_comb begin
    w_busy_d = (w_state_d == StRun);
    w_tc_d   = (w_state_d == StRun) && (w_count_d == w_lo_d);
    w_done_d = (w_state_d == StDone);
  end

  assign o_count   = r_count;
  assign o_busy    = r_busy;
  assign o_tc      = r_tc;
  assign o_done    = r_done;
  assign o_wraps   = r_wraps;
  assign o_cfg_err = r_cfg_err;

endmodule

// File: tb/tb_range_down_counter.sv
// Directed bench for range_down_counter: expected outputs are queued as each step is driven
// and popped for comparison one clock later.
module tb_range_down_counter;

  logic       clk;
  logic       reset;
  logic       start, stop, oneshot, en, load;
  logic [3:0] load_val, hi, lo;
  logic [3:0] count;
  logic       busy, tc, done, cfg_err;
  logic [7:0] wraps;

  typedef struct {
    string       tag;
    logic [15:0] val;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  range_down_counter #(.WIDTH(4), .HI_DEF(12), .LO_DEF(3)) dut (
    .clk       (clk),
    .reset     (reset),
    .i_start   (start),
    .i_stop    (stop),
    .i_oneshot (oneshot),
    .i_en      (en),
    .i_load    (load),
    .i_load_val(load_val),
    .i_hi      (hi),
    .i_lo      (lo),
    .o_count   (count),
    .o_busy    (busy),
    .o_tc      (tc),
    .o_done    (done),
    .o_wraps   (wraps),
    .o_cfg_err (cfg_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive(input logic st, input logic sp, input logic os, input logic e,
                       input logic ld, input logic [3:0] lv, input logic [3:0] h,
                       input logic [3:0] l);
    start = st; stop = sp; oneshot = os; en = e; load = ld; load_val = lv; hi = h; lo = l;
  endtask

  // Queue the expectation for the current inputs, clock once, then pop and compare.
  task automatic check(input string tag, input logic [3:0] c, input logic b, input logic t,
                       input logic d, input logic [7:0] w, input logic e);
    exp_t        x;
    logic [15:0] obs;
    sb.push_back('{tag, {c, b, t, d, w, e}});
    @(posedge clk);
    #1;
    x   = sb.pop_front();
    obs = {count, busy, tc, done, wraps, cfg_err};
    n_cmp++;
    assert (obs === x.val) else begin
      n_err++;
      $error("FAIL %s: observed cnt/busy/tc/done/wraps/err=%h expected %h", x.tag, obs, x.val);
    end
  endtask

  initial begin
    reset = 1'b1;
    drive(0, 0, 0, 0, 0, 4'd0, 4'd0, 4'd0);
    check("reset", 4'd12, 0, 0, 0, 8'd0, 0);
    reset = 1'b0;
    check("idle_hold", 4'd12, 0, 0, 0, 8'd0, 0);

    // Continuous wrap 12..3
    drive(1, 0, 0, 0, 0, 4'd0, 4'd12, 4'd3);
    check("cont_start", 4'd12, 1, 0, 0, 8'd0, 0);
    drive(0, 0, 0, 1, 0, 4'd0, 4'd0, 4'd0);
    for (int i = 1; i <= 12; i++) begin
      int ex;
      ex = (i <= 9) ? 12 - i : 22 - i;
      check("cont_run", 4'(ex), 1, ex == 3, 0, (i >= 10) ? 8'd1 : 8'd0, 0);
    end
    drive(0, 1, 0, 0, 0, 4'd0, 4'd0, 4'd0);
    check("cont_stop", 4'd10, 0, 0, 0, 8'd1, 0);

    // One-shot 12..3
    drive(1, 0, 1, 0, 0, 4'd0, 4'd12, 4'd3);
    check("os_start", 4'd12, 1, 0, 0, 8'd0, 0);
    drive(0, 0, 0, 1, 0, 4'd0, 4'd0, 4'd0);
    for (int i = 1; i <= 9; i++) check("os_run", 4'(12 - i), 1, i == 9, 0, 8'd0, 0);
    check("os_done", 4'd3, 0, 0, 1, 8'd0, 0);
    check("os_done_hold", 4'd3, 0, 0, 1, 8'd0, 0);
    drive(1, 0, 0, 0, 0, 4'd0, 4'd6, 4'd3);
    check("os_restart", 4'd6, 1, 0, 0, 8'd0, 0);
    drive(1, 0, 0, 0, 0, 4'd0, 4'd9, 4'd1);
    check("start_in_run", 4'd6, 1, 0, 0, 8'd0, 0);
    drive(0, 1, 0, 0, 0, 4'd0, 4'd0, 4'd0);
    check("stop_idle", 4'd6, 0, 0, 0, 8'd0, 0);

    // Config error from reset state
    reset = 1'b1;
    check("reset2", 4'd12, 0, 0, 0, 8'd0, 0);
    reset = 1'b0;
    drive(1, 0, 0, 1, 0, 4'd0, 4'd2, 4'd5);
    check("cfg_err", 4'd12, 0, 0, 0, 8'd0, 1);
    drive(0, 0, 0, 0, 0, 4'd0, 4'd0, 4'd0);
    check("cfg_err_clr", 4'd12, 0, 0, 0, 8'd0, 0);

    // Load, including both bounds
    drive(1, 0, 0, 0, 0, 4'd0, 4'd12, 4'd3);
    check("ld_start", 4'd12, 1, 0, 0, 8'd0, 0);
    drive(0, 0, 0, 1, 0, 4'd0, 4'd0, 4'd0);
    check("ld_dec", 4'd11, 1, 0, 0, 8'd0, 0);
    drive(0, 0, 0, 1, 1, 4'd7, 4'd0, 4'd0);
    check("ld_7", 4'd7, 1, 0, 0, 8'd0, 0);
    drive(0, 0, 0, 1, 1, 4'd13, 4'd0, 4'd0);
    check("ld_13_err", 4'd7, 1, 0, 0, 8'd0, 1);
    drive(0, 0, 0, 1, 0, 4'd0, 4'd0, 4'd0);
    check("ld_continue", 4'd6, 1, 0, 0, 8'd0, 0);
    drive(0, 0, 0, 0, 1, 4'd3, 4'd0, 4'd0);
    check("ld_lo", 4'd3, 1, 1, 0, 8'd0, 0);
    drive(0, 0, 0, 0, 1, 4'd2, 4'd0, 4'd0);
    check("ld_2_err", 4'd3, 1, 1, 0, 8'd0, 1);
    drive(0, 0, 0, 1, 0, 4'd0, 4'd0, 4'd0);
    check("ld_wrap", 4'd12, 1, 0, 0, 8'd1, 0);

    // Enable gating and stop
    drive(0, 1, 0, 0, 0, 4'd0, 4'd0, 4'd0);
    check("en_stop", 4'd12, 0, 0, 0, 8'd1, 0);
    drive(1, 0, 0, 0, 0, 4'd0, 4'd12, 4'd3);
    check("en_start", 4'd12, 1, 0, 0, 8'd0, 0);
    drive(0, 0, 0, 1, 0, 4'd0, 4'd0, 4'd0);
    check("en_1a", 4'd11, 1, 0, 0, 8'd0, 0);
    en = 1'b0;
    check("en_0a", 4'd11, 1, 0, 0, 8'd0, 0);
    en = 1'b1;
    check("en_1b", 4'd10, 1, 0, 0, 8'd0, 0);
    en = 1'b0;
    check("en_0b", 4'd10, 1, 0, 0, 8'd0, 0);
    en = 1'b1;
    check("en_1c", 4'd9, 1, 0, 0, 8'd0, 0);
    check("en_1d", 4'd8, 1, 0, 0, 8'd0, 0);
    stop = 1'b1;
    check("stop_at_8", 4'd8, 0, 0, 0, 8'd0, 0);

    // Degenerate hi == lo, continuous, wrap tally saturates
    drive(1, 0, 0, 0, 0, 4'd0, 4'd5, 4'd5);
    check("deg_start", 4'd5, 1, 1, 0, 8'd0, 0);
    drive(0, 0, 0, 1, 0, 4'd0, 4'd0, 4'd0);
    for (int i = 1; i <= 300; i++) begin
      check("deg_run", 4'd5, 1, 1, 0, (i > 255) ? 8'd255 : 8'(i), 0);
    end
    reset = 1'b1;
    check("reset_mid_run", 4'd12, 0, 0, 0, 8'd0, 0);
    reset = 1'b0;

    // Degenerate one-shot, then rejected start in DONE
    drive(1, 0, 1, 0, 0, 4'd0, 4'd5, 4'd5);
    check("deg_os_start", 4'd5, 1, 1, 0, 8'd0, 0);
    drive(0, 0, 0, 1, 0, 4'd0, 4'd0, 4'd0);
    check("deg_os_done", 4'd5, 0, 0, 1, 8'd0, 0);
    drive(1, 0, 0, 0, 0, 4'd0, 4'd2, 4'd5);
    check("done_cfg_err", 4'd5, 0, 0, 1, 8'd0, 1);
    drive(0, 1, 0, 0, 0, 4'd0, 4'd0, 4'd0);
    check("done_stop", 4'd5, 0, 0, 0, 8'd0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
